uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL expose parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL expose parameter BAUD, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide).
REQ-003 SHALL expose parameter DATA_BITS, default 8, legal 5..9, payload bits per frame.
REQ-004 SHALL expose parameter PARITY, default 0; 0 none, 1 odd, 2 even.
REQ-005 SHALL expose parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL expose parameter FIFO_DEPTH, default 4, power of two >= 2, receive buffer entries.
REQ-007 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-009 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_o, output, DATA_BITS, FIFO head word, LSB = first received bit.
REQ-011 SHALL have port valid_o, output, 1, high while FIFO non-empty.
REQ-012 SHALL have port ready_i, input, 1, consumer accepts data_o when valid_o and ready_i high on a clock edge.
REQ-013 SHALL have ports parity_err_o, frame_err_o, overrun_o, output, 1 each, one-cycle error pulses.
REQ-014 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 SHALL pass rx_i through a two-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE: rx_s = 0 -> START with bit counter cleared; else stay.
REQ-018 START: at CLKS_PER_BIT/2 cycles after entry sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag).
REQ-019 DATA: sample every CLKS_PER_BIT cycles from START midpoint, shift LSB-first, after DATA_BITS samples -> PARITY if PARITY != 0 else STOP.
REQ-020 PARITY: sample one bit; odd mode error if XOR(data,bit) = 0, even mode error if XOR(data,bit) = 1; -> STOP.
REQ-021 STOP: sample STOP_BITS bits at bit midpoints; any sample 0 is frame error.
REQ-022 At final stop sample, no errors: push word into FIFO in that cycle; -> IDLE.
REQ-023 Frame error: discard word, pulse frame_err_o, -> WAIT_IDLE; WAIT_IDLE -> IDLE on first cycle rx_s = 1.
REQ-024 Parity error without frame error: discard word, pulse parity_err_o, -> IDLE; both errors: frame_err_o only.
REQ-025 Push while FIFO full and no pop in the same cycle: drop new word, pulse overrun_o, FIFO contents unchanged.
REQ-026 Push and pop in same cycle: both occur; when full this is no overrun, count_o unchanged.
REQ-027 Pop on valid_o && ready_i; ready_i with FIFO empty has no effect.
REQ-028 valid_o, data_o, count_o reflect a push on the cycle after the push edge (one-cycle latency from final stop sample).
REQ-029 data_o SHALL hold stable while valid_o high and ready_i low.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH; count_o ranges 0..FIFO_DEPTH.

Reset
REQ-031 reset_i high on an edge SHALL force state IDLE, counters 0, FIFO empty, synchronizer flops 1.
REQ-032 During/after reset: valid_o 0, data_o 0, count_o 0, all error pulses 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse.

Verification (CLK_FREQ 100e6, BAUD 9600, CLKS_PER_BIT 10416)
REQ-034 Defaults, frames 0x81 then 0x80, ready_i low -> count_o 2, data_o 0x81; pulse ready_i -> data_o 0x80, count_o 1.
REQ-035 rx_i low for 2000 ns then high -> stays IDLE, no push, no error pulses.
REQ-036 PARITY=2, frame 0x03 with parity bit 1 -> parity_err_o one pulse, count_o 0; parity bit 0 -> 0x03 pushed.
REQ-037 Frame 0x55 with stop bit 0, line held low 3 bit times -> frame_err_o one pulse, no push, next valid frame 0xA5 received.
REQ-038 FIFO_DEPTH 4, 5 frames 0x01..0x05, no pops -> overrun_o pulse on fifth, drain yields 0x01..0x04.
REQ-039 DATA_BITS=7, STOP_BITS=2, frame 0x7F; reset_i during bit 4 of second frame -> count_o 0 after reset, next frame 0x2A received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a receive FIFO.
//
// Ports:
//   clk_i        - system clock, rising edge
//   reset_i      - synchronous active-high reset
//   rx_i         - asynchronous serial line, idle high
//   data_o       - FIFO head word, LSB is the first received bit (0 when empty)
//   valid_o      - FIFO non-empty
//   ready_i      - consumer pops the head when valid_o && ready_i
//   parity_err_o - one-cycle pulse: frame discarded for bad parity
//   frame_err_o  - one-cycle pulse: frame discarded for a low stop bit
//   overrun_o    - one-cycle pulse: good frame dropped because the FIFO was full
//   count_o      - FIFO occupancy, 0..FIFO_DEPTH
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         rx_i,
    input  logic                         ready_i,
    output logic [DATA_BITS-1:0]         data_o,
    output logic                         valid_o,
    output logic                         parity_err_o,
    output logic                         frame_err_o,
    output logic                         overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned HalfBit    = (ClksPerBit / 2 > 0) ? ClksPerBit / 2 : 1;
    localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitIdle
    } state_e;

    logic                 rx_meta_q, rx_s_q;
    state_e               state_q, state_d;
    logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frm_bad_q, frm_bad_d;
    logic                 push_req;
    logic                 parity_err_d, frame_err_d, overrun_d;
    logic                 parity_err_q, frame_err_q, overrun_q;
    logic                 bit_tick;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]        count_q, count_d;
    logic                 full, empty, push, pop;

    // Synchronizer resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign bit_tick = (clk_cnt_q == CntW'(ClksPerBit - 1));

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frm_bad_d    = frm_bad_q;
        push_req     = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                par_bad_d = 1'b0;
                frm_bad_d = 1'b0;
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                // Re-check at mid start bit; a high line here was only a glitch.
                if (clk_cnt_q == CntW'(HalfBit - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    state_d   = StStop;
                    if (PARITY == 1) par_bad_d = ~(^shift_q ^ rx_s_q);
                    else             par_bad_d = ^shift_q ^ rx_s_q;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (!rx_s_q) frm_bad_d = 1'b1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        // Framing error takes precedence over parity error.
                        if (frm_bad_q || !rx_s_q) begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitIdle;
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            push_req = 1'b1;
                            state_d  = StIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                clk_cnt_d = '0;
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Receive FIFO. A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = !empty && ready_i;
    assign push      = push_req && (!full || pop);
    assign overrun_d = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign data_o       = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o      = !empty;
    assign count_o      = count_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;

endmodule
